controller: RTL and testbench

- Sequential single-car elevator controller for a 4-floor shaft (floors 0..3).
- Latches per-floor call requests and moves the cabin one floor at a time, serving calls with a SCAN (continue-in-direction) policy.
- Reports the cabin's current floor as a 2-bit code.
- Sits between the floor call-button logic and the motor/door drivers.

---
 rtl/controller.sv | 179 +++++++++++++++++
 tb/tb_controller.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/controller.sv
// Single-car SCAN elevator controller for a 4-floor shaft (floors 0..3).
// Latency: a latched call is acted on the clock after it is seen; one floor takes STEP_CYCLES clocks.
// No backpressure: input_floor is a level sampled every clock and OR-ed into pending.
//
// Ports:
//   clk                 rising-edge system clock
//   rst_n               asynchronous active-low reset
//   input_floor[3:0]    call requests, bit i = call from floor i
//   output_description  current cabin floor, binary 0..3
//   moving              high while the cabin travels between floors
//   dir_up              current / last travel direction (1 = up)
//   door_open           high while the door is open at a stop
//   pending[3:0]        latched outstanding calls
//
// Optional build macro HOME_RETURN_EN: after 16 consecutive idle cycles with
// no calls and the cabin away from floor 0, an internal call to floor 0 is raised.
module controller #(
    parameter int STEP_CYCLES = 4,
    parameter int DOOR_CYCLES = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] input_floor,
    output logic [1:0] output_description,
    output logic       moving,
    output logic       dir_up,
    output logic       door_open,
    output logic [3:0] pending
);

    localparam int MAXC  = (STEP_CYCLES > DOOR_CYCLES) ? STEP_CYCLES : DOOR_CYCLES;
    localparam int CNT_W = (MAXC > 1) ? $clog2(MAXC) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_MOVING = 2'd1,
        S_DOOR   = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [1:0]       floor_nxt;
    logic             dir_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [3:0]       clear_mask;
    logic [3:0]       set_mask;
    logic [3:0]       p_eff;
    logic [1:0]       floor_step;
    logic             home_req;

    // Bits strictly above / strictly below a floor.
    function automatic logic [3:0] up_mask(input logic [1:0] f);
        return 4'(4'b1110 << f);
    endfunction

    function automatic logic [3:0] dn_mask(input logic [1:0] f);
        return 4'(~(4'b1111 << f));
    endfunction

    function automatic logic [3:0] onehot(input logic [1:0] f);
        return 4'(4'b0001 << f);
    endfunction

`ifdef HOME_RETURN_EN
    logic [3:0] idle_cnt;
    logic       home_cond;

    assign home_cond = (state == S_IDLE) && (pending == 4'b0000) &&
                       (output_description != 2'd0);
    assign home_req  = home_cond && (idle_cnt == 4'd15);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if (!home_cond || home_req) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 4'd1;
        end
    end
`else
    assign home_req = 1'b0;
`endif

    assign set_mask = {3'b000, home_req};
    // Arrival decisions include calls that show up on the same clock.
    assign p_eff    = pending | input_floor;

    // The cabin never leaves 0..3; a step past an end saturates.
    always_comb begin
        floor_step = output_description;
        if (dir_up && output_description != 2'd3) begin
            floor_step = output_description + 2'd1;
        end else if (!dir_up && output_description != 2'd0) begin
            floor_step = output_description - 2'd1;
        end
    end

    always_comb begin
        state_nxt  = state;
        floor_nxt  = output_description;
        dir_nxt    = dir_up;
        cnt_nxt    = cnt;
        clear_mask = 4'b0000;
        case (state)
            S_IDLE: begin
                cnt_nxt = '0;
                if (pending[output_description]) begin
                    state_nxt  = S_DOOR;
                    clear_mask = onehot(output_description);
                end else if (|(pending & (dir_up ? up_mask(output_description)
                                                 : dn_mask(output_description)))) begin
                    state_nxt = S_MOVING;
                end else if (|(pending & (dir_up ? dn_mask(output_description)
                                                 : up_mask(output_description)))) begin
                    state_nxt = S_MOVING;
                    dir_nxt   = ~dir_up;
                end
            end
            S_MOVING: begin
                if (cnt == CNT_W'(STEP_CYCLES - 1)) begin
                    cnt_nxt   = '0;
                    floor_nxt = floor_step;
                    if (p_eff[floor_step]) begin
                        state_nxt  = S_DOOR;
                        clear_mask = onehot(floor_step);
                    end else if (|(p_eff & (dir_up ? up_mask(floor_step)
                                                   : dn_mask(floor_step)))) begin
                        state_nxt = S_MOVING;
                    end else if (|(p_eff & (dir_up ? dn_mask(floor_step)
                                                   : up_mask(floor_step)))) begin
                        state_nxt = S_MOVING;
                        dir_nxt   = ~dir_up;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            S_DOOR: begin
                if (input_floor[output_description]) begin
                    // A call for the open floor is absorbed and holds the door.
                    cnt_nxt    = '0;
                    clear_mask = onehot(output_description);
                end else if (cnt == CNT_W'(DOOR_CYCLES - 1)) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= S_IDLE;
            output_description <= 2'd0;
            dir_up             <= 1'b1;
            cnt                <= '0;
            pending            <= 4'b0000;
            moving             <= 1'b0;
            door_open          <= 1'b0;
        end else begin
            state              <= state_nxt;
            output_description <= floor_nxt;
            dir_up             <= dir_nxt;
            cnt                <= cnt_nxt;
            pending            <= (pending | input_floor | set_mask) & ~clear_mask;
            moving             <= (state_nxt == S_MOVING);
            door_open          <= (state_nxt == S_DOOR);
        end
    end

endmodule

// File: tb/tb_controller.sv
// Self-checking bench for the SCAN elevator controller.
// Expected service floors are queued when calls are driven and popped on each door opening.
// All waits are bounded by a cycle budget.
module tb_controller;

    logic       clk;
    logic       rst_n;
    logic [3:0] input_floor;
    logic [1:0] output_description;
    logic       moving;
    logic       dir_up;
    logic       door_open;
    logic [3:0] pending;

    int checks   = 0;
    int failures = 0;
    int sb[$];
    logic door_q = 1'b0;

    controller #(.STEP_CYCLES(4), .DOOR_CYCLES(3)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .input_floor        (input_floor),
        .output_description (output_description),
        .moving             (moving),
        .dir_up             (dir_up),
        .door_open          (door_open),
        .pending            (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        input_floor = 4'b0000;
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_door(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (door_open) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    // Service monitor: each door opening must match the next expected floor.
    always @(negedge clk) begin
        if (rst_n && door_open && !door_q) begin
            if (sb.size() == 0) begin
                check("svc_unexpected", int'(output_description), -1);
            end else begin
                check("svc_floor", int'(output_description), sb.pop_front());
                check("svc_not_moving", int'(moving), 0);
            end
        end
        door_q = rst_n ? door_open : 1'b0;
    end

    initial begin
        bit ok;
        int cnt;
        rst_n       = 1'b0;
        input_floor = 4'b0000;

        // Reset, then idle with no calls.
        do_reset();
        repeat (20) step();
        check("idle_floor", int'(output_description), 0);
        check("idle_moving", int'(moving), 0);
        check("idle_door", int'(door_open), 0);
        check("idle_pending", int'(pending), 0);
        check("idle_dir", int'(dir_up), 1);

        // Call at the current floor: door opens for exactly three cycles.
        sb.push_back(0);
        input_floor = 4'b0001;
        step();
        input_floor = 4'b0000;
        check("here_latch", int'(pending), 1);
        step();
        check("here_door", int'(door_open), 1);
        check("here_clear", int'(pending), 0);
        cnt = 0;
        for (int i = 0; i < 20 && door_open; i++) begin
            cnt++;
            check("here_floor", int'(output_description), 0);
            step();
        end
        check("here_door_len", cnt, 3);

        // Travel up from floor 0 to floor 2 with the exact cycle timeline.
        sb.push_back(2);
        input_floor = 4'b0100;
        step();                                   // E0
        input_floor = 4'b0000;
        step();                                   // E1
        check("up_e1_moving", int'(moving), 1);
        repeat (4) step();                        // E5
        check("up_e5_floor", int'(output_description), 1);
        check("up_e5_moving", int'(moving), 1);
        repeat (4) step();                        // E9
        check("up_e9_floor", int'(output_description), 2);
        check("up_e9_door", int'(door_open), 1);
        check("up_e9_pending", int'(pending), 0);
        repeat (2) step();                        // E11
        check("up_e11_door", int'(door_open), 1);
        step();                                   // E12
        check("up_e12_door", int'(door_open), 0);
        check("up_e12_moving", int'(moving), 0);

        // SCAN order: floor 3 served before floor 0 when passing floor 1 upward.
        do_reset();
        sb.push_back(3);
        sb.push_back(0);
        input_floor = 4'b1000;
        step();
        input_floor = 4'b0000;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (output_description == 2'd1) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        check("scan_reach1", int'(ok), 1);
        check("scan_at1_moving", int'(moving), 1);
        input_floor = 4'b0001;
        step();
        input_floor = 4'b0000;
        wait_door(100, ok);
        check("scan_door3_seen", int'(ok), 1);
        check("scan_door3_floor", int'(output_description), 3);
        check("scan_door3_dir", int'(dir_up), 1);
        for (int i = 0; i < 20 && door_open; i++) step();
        wait_door(100, ok);
        check("scan_door0_seen", int'(ok), 1);
        check("scan_door0_floor", int'(output_description), 0);
        check("scan_door0_dir", int'(dir_up), 0);
        for (int i = 0; i < 20 && door_open; i++) step();
        check("scan_pending", int'(pending), 0);
        check("scan_sb_empty", sb.size(), 0);

        // Every call pattern held five cycles from floor 0 (direction up):
        // served lowest to highest.
        for (int p = 0; p < 16; p++) begin
            logic [3:0] pat;
            pat = 4'(p);
            do_reset();
            for (int f = 0; f < 4; f++) begin
                if (pat[f]) sb.push_back(f);
            end
            input_floor = pat;
            repeat (5) step();
            input_floor = 4'b0000;
            ok = 1'b0;
            for (int i = 0; i < 300; i++) begin
                if (sb.size() == 0 && pending == 4'b0000 && !moving && !door_open) begin
                    ok = 1'b1;
                    break;
                end
                step();
            end
            check($sformatf("exh_drain_%0d", p), int'(ok), 1);
            check($sformatf("exh_pending_%0d", p), int'(pending), 0);
        end

        // Asynchronous reset between floors clears everything without a clock edge.
        do_reset();
        input_floor = 4'b1000;
        step();
        input_floor = 4'b0000;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (output_description == 2'd1) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        step();
        step();
        check("arst_pre_moving", int'(moving), 1);
        check("arst_pre_pending", int'(pending), 8);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_floor", int'(output_description), 0);
        check("arst_moving", int'(moving), 0);
        check("arst_door", int'(door_open), 0);
        check("arst_pending", int'(pending), 0);
        check("arst_dir", int'(dir_up), 1);
        sb.delete();
        step();
        rst_n = 1'b1;
        repeat (10) step();
        check("arst_stays_idle", int'(moving), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
